// File: rtl/fifo_ser_tx_if.sv
// FIFO read-side handshake between regb_fifo (master) and fifo_ser_tx (slave).
interface fifo_ser_tx_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             empty;
  logic [WIDTH-1:0] rdata;
  logic             shift_out;

  modport master (output empty, output rdata, input shift_out);
  modport slave  (input empty, input rdata, output shift_out);
endinterface

// File: rtl/fifo_ser_tx.sv
// Bit-serial UART-style transmitter draining a regb_fifo read port.
// Define FIFO_SER_TX_PARITY_EN to insert an even-parity bit before stop.
module fifo_ser_tx #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             en,
  fifo_ser_tx_if.slave     fifo,
  output logic             ser_out,
  output logic             busy,
  output logic [CNT_W-1:0] frames_sent
);
  localparam int unsigned BCW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BCW-1:0]  BIT_LAST = BCW'(CLKS_PER_BIT - 1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd4;
`ifdef FIFO_SER_TX_PARITY_EN
  localparam logic [2:0] S_PAR   = 3'd3;
  logic par_bit;
`endif

  logic [2:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [BCW-1:0]   bit_cnt;
  logic [IDXW-1:0]  bit_idx;
  logic             bit_end;

  assign bit_end = (bit_cnt == BIT_LAST);

  // Pop is gated by res_n so the strobe is low while reset is held.
  always_comb fifo.shift_out = res_n && (state == S_IDLE) && en && !fifo.empty;

  always_comb busy = (state != S_IDLE);

  always_comb begin
    ser_out = 1'b1;
    case (state)
      S_START: ser_out = 1'b0;
      S_DATA:  ser_out = shreg[0];
`ifdef FIFO_SER_TX_PARITY_EN
      S_PAR:   ser_out = par_bit;
`endif
      default: ser_out = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state       <= S_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      frames_sent <= '0;
`ifdef FIFO_SER_TX_PARITY_EN
      par_bit     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (fifo.shift_out) begin
            shreg   <= fifo.rdata;
            bit_cnt <= '0;
            bit_idx <= '0;
`ifdef FIFO_SER_TX_PARITY_EN
            par_bit <= ^fifo.rdata;
`endif
            state   <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            state   <= S_DATA;
          end else begin
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            shreg   <= shreg >> 1;
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
`ifdef FIFO_SER_TX_PARITY_EN
              state   <= S_PAR;
`else
              state   <= S_STOP;
`endif
            end else begin
              bit_idx <= bit_idx + IDXW'(1);
            end
          end else begin
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end
`ifdef FIFO_SER_TX_PARITY_EN
        S_PAR: begin
          if (bit_end) begin
            bit_cnt <= '0;
            state   <= S_STOP;
          end else begin
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_end) begin
            bit_cnt     <= '0;
            frames_sent <= frames_sent + CNT_W'(1);
            state       <= S_IDLE;
          end else begin
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_ser_tx.sv
// Scoreboard bench for fifo_ser_tx: queue-based FIFO model plus a serial frame decoder.
module tb_fifo_ser_tx;
`ifdef FIFO_SER_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int W      = 16;
  localparam int CPB    = 4;
  localparam int FRAME  = (W + 2 + P) * CPB;
  localparam int PERIOD = FRAME + 1;

  logic        clk = 1'b0;
  logic        res_n;
  logic        en, en2;
  logic        ser_out, busy, ser2, busy2;
  logic [15:0] frames_sent;
  logic [1:0]  frames2;

  fifo_ser_tx_if #(.WIDTH(W)) fif ();
  fifo_ser_tx_if #(.WIDTH(W)) fif2 ();

  fifo_ser_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
    .clk(clk), .res_n(res_n), .en(en), .fifo(fif),
    .ser_out(ser_out), .busy(busy), .frames_sent(frames_sent)
  );

  fifo_ser_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .CNT_W(2)) u_wrap (
    .clk(clk), .res_n(res_n), .en(en2), .fifo(fif2),
    .ser_out(ser2), .busy(busy2), .frames_sent(frames2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int pops   = 0;
  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];
  int          start_q[$];

  always @(posedge clk) cyc++;

  // FIFO model: pop on the sampling edge, head/empty update just after it.
  always @(posedge clk) begin
    if (fif.shift_out) begin
      checks++;
      if (fifo_q.size() == 0) begin
        fails++;
        $display("FAIL pop_when_empty: shift_out=1 required 0 at cycle %0d", cyc);
      end else begin
        void'(fifo_q.pop_front());
      end
      pops++;
    end
    #1;
    fif.empty = (fifo_q.size() == 0);
    fif.rdata = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  end

  // Frame decoder: samples each bit mid-cell, compares against the scoreboard.
  initial begin
    logic [15:0] word, exp;
    logic        stopbit, parbit, abort;
    forever begin
      @(negedge clk);
      if (res_n && busy && !ser_out) begin
        start_q.push_back(cyc);
        word = '0; stopbit = 1'b0; parbit = 1'b0; abort = 1'b0;
        for (int c = 1; c < FRAME; c++) begin
          @(negedge clk);
          if (!res_n) begin abort = 1'b1; break; end
          if (c >= CPB && c < (W + 1) * CPB && (c % CPB) == CPB / 2)
            word[(c - CPB) / CPB] = ser_out;
          if (c == (W + 1) * CPB + CPB / 2) parbit = ser_out;
          if (c == (W + 1 + P) * CPB + CPB / 2) stopbit = ser_out;
        end
        if (abort) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          wait (res_n);
        end else begin
          checks++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL frame_unexpected: got word %h, required no frame", word);
          end else begin
            exp = exp_q.pop_front();
            if (word !== exp) begin
              fails++;
              $display("FAIL frame_data: got %h required %h", word, exp);
            end
          end
          checks++;
          if (stopbit !== 1'b1) begin
            fails++;
            $display("FAIL frame_stop: got %b required 1", stopbit);
          end
`ifdef FIFO_SER_TX_PARITY_EN
          checks++;
          if (parbit !== ^word) begin
            fails++;
            $display("FAIL frame_parity: got %b required %b", parbit, ^word);
          end
`endif
        end
      end
    end
  end

  task automatic push_word(input logic [15:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fif.empty = 1'b0;
    fif.rdata = fifo_q[0];
  endtask

  // Returns just after the pop edge; ok=0 if no pop within limit cycles.
  task automatic wait_pop(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (fif.shift_out) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
  endtask

  task automatic wait_frames(input logic [15:0] target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (frames_sent == target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    int p0;
    res_n = 1'b0; en = 1'b1; en2 = 1'b0;
    fif.empty = 1'b1; fif.rdata = '0;
    fif2.empty = 1'b0; fif2.rdata = 16'hFFFF;
    #1;
    checks++;
    if ({ser_out, busy, fif.shift_out} !== 3'b100) begin
      fails++;
      $display("FAIL reset_outputs: ser/busy/shift got %b required 100", {ser_out, busy, fif.shift_out});
    end
    checks++;
    if (frames_sent !== 16'd0) begin
      fails++;
      $display("FAIL reset_frames: got %0d required 0", frames_sent);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) res_n = 1'b1;
    p0 = pops;
    repeat (50) @(posedge clk);
    #1;
    checks++;
    if (pops != p0 || busy !== 1'b0 || ser_out !== 1'b1) begin
      fails++;
      $display("FAIL idle_empty: pops %0d busy %b ser %b required 0 0 1", pops - p0, busy, ser_out);
    end
  endtask

  task automatic test_single;
    bit ok;
    int p0;
    @(negedge clk);
    p0 = pops;
    push_word(16'hA5C3);
    #1;
    wait_pop(5, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL single_pop: got timeout required pop"); end
    #1;
    checks++;
    if (busy !== 1'b1 || ser_out !== 1'b0) begin
      fails++;
      $display("FAIL single_start: busy %b ser %b required 1 0", busy, ser_out);
    end
    repeat (FRAME - 1) @(posedge clk);
    #1;
    checks++;
    if (frames_sent !== 16'd0 || busy !== 1'b1 || ser_out !== 1'b1) begin
      fails++;
      $display("FAIL single_last_stop: frames %0d busy %b ser %b required 0 1 1", frames_sent, busy, ser_out);
    end
    @(posedge clk);
    #1;
    checks++;
    if (frames_sent !== 16'd1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_done: frames %0d busy %b required 1 0", frames_sent, busy);
    end
    checks++;
    if (pops - p0 != 1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL single_count: pops %0d pending %0d required 1 0", pops - p0, exp_q.size());
    end
  endtask

  task automatic test_drain;
    bit ok;
    int p0;
    logic [15:0] f0;
    en = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) push_word(16'($urandom));
    start_q.delete();
    f0 = frames_sent;
    p0 = pops;
    en = 1'b1;
    wait_frames(f0 + 16'd5, 6 * PERIOD, ok);
    checks++;
    if (!ok || frames_sent !== f0 + 16'd5) begin
      fails++;
      $display("FAIL drain_frames: got %0d required %0d", frames_sent, f0 + 16'd5);
    end
    checks++;
    if (pops - p0 != 5 || start_q.size() != 5) begin
      fails++;
      $display("FAIL drain_pops: pops %0d starts %0d required 5 5", pops - p0, start_q.size());
    end
    for (int i = 1; i < start_q.size(); i++) begin
      checks++;
      if (start_q[i] - start_q[i-1] != PERIOD) begin
        fails++;
        $display("FAIL drain_spacing: got %0d required %0d", start_q[i] - start_q[i-1], PERIOD);
      end
    end
    checks++;
    if (fif.empty !== 1'b1 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_empty: empty %b pending %0d required 1 0", fif.empty, exp_q.size());
    end
  endtask

  task automatic test_enable;
    bit ok;
    int p0;
    logic [15:0] f0;
    en = 1'b0;
    @(negedge clk);
    push_word(16'h0F0F);
    push_word(16'h8001);
    #1;
    f0 = frames_sent;
    p0 = pops;
    en = 1'b1;
    wait_pop(5, ok);
    repeat (20) @(posedge clk);
    @(negedge clk) en = 1'b0;
    wait_frames(f0 + 16'd1, FRAME + 5, ok);
    checks++;
    if (!ok) begin fails++; $display("FAIL enable_first: got timeout required frame"); end
    repeat (20) @(negedge clk);
    checks++;
    if (pops - p0 != 1 || busy !== 1'b0 || fif.empty !== 1'b0) begin
      fails++;
      $display("FAIL enable_hold: pops %0d busy %b empty %b required 1 0 0", pops - p0, busy, fif.empty);
    end
    en = 1'b1;
    #1;
    checks++;
    if (fif.shift_out !== 1'b1) begin
      fails++;
      $display("FAIL enable_resume: shift_out %b required 1", fif.shift_out);
    end
    wait_frames(f0 + 16'd2, PERIOD + 5, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      fails++;
      $display("FAIL enable_second: frames %0d pending %0d required %0d 0", frames_sent, exp_q.size(), f0 + 16'd2);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int p0;
    en = 1'b0;
    @(negedge clk);
    push_word(16'h1234);
    push_word(16'h5A0F);
    #1;
    en = 1'b1;
    wait_pop(5, ok);
    repeat (CPB + 7 * CPB + 2) @(posedge clk);
    #2;
    checks++;
    if (ser_out !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL midreset_bit7: ser %b busy %b required 0 1", ser_out, busy);
    end
    res_n = 1'b0;
    #1;
    checks++;
    if ({ser_out, busy, fif.shift_out} !== 3'b100 || frames_sent !== 16'd0) begin
      fails++;
      $display("FAIL midreset_async: ser/busy/shift %b frames %0d required 100 0",
               {ser_out, busy, fif.shift_out}, frames_sent);
    end
    @(negedge clk);
    @(negedge clk) res_n = 1'b1;
    p0 = pops;
    wait_frames(16'd1, PERIOD + 10, ok);
    checks++;
    if (!ok || pops - p0 != 1 || exp_q.size() != 0 || fif.empty !== 1'b1) begin
      fails++;
      $display("FAIL midreset_next: pops %0d pending %0d empty %b required 1 0 1",
               pops - p0, exp_q.size(), fif.empty);
    end
  endtask

  task automatic test_wrap;
    int n;
    n = 0;
    @(negedge clk) en2 = 1'b1;
    #1;
    for (int i = 0; i < 6 * PERIOD; i++) begin
      if (fif2.shift_out) n++;
      if (n == 5) break;
      @(negedge clk);
    end
    @(posedge clk);
    #1 en2 = 1'b0;
    for (int i = 0; i < FRAME + 10; i++) begin
      @(negedge clk);
      if (!busy2) break;
    end
    repeat (10) @(negedge clk);
    checks++;
    if (n != 5 || busy2 !== 1'b0) begin
      fails++;
      $display("FAIL wrap_pops: pops %0d busy %b required 5 0", n, busy2);
    end
    checks++;
    if (frames2 !== 2'd1) begin
      fails++;
      $display("FAIL wrap_count: got %0d required 1", frames2);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_drain;
    test_enable;
    test_reset_mid;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end
endmodule

// File: doc/fifo_ser_tx.md
# fifo_ser_tx

Bit-serial transmitter that drains the read side of the register-based FIFO (`regb_fifo`). It pops one WIDTH-bit word whenever the FIFO is non-empty and transmission is enabled. Each word goes out on a single line as a UART-style frame: start bit, data LSB first, optional parity, stop bit. It sits between the FIFO and an off-block serial link, the consumer end of the FIFO's `shift_out`/`rdata`/`empty` interface.

## Interface
- `WIDTH`, 16, data word width; must match the attached FIFO's WIDTH
- `CLKS_PER_BIT`, 4, clock cycles per serial bit; ≥ 2
- `CNT_W`, 16, width of the sent-frame counter
- `clk`  in  1  clock; all state changes on rising edge
- `res_n`  in  1  reset; one clock; reset is asynchronous and active-low
- `en`  in  1  permits starting a new frame; sampled only in IDLE
- `empty`  in  1  FIFO empty flag
- `rdata`  in  WIDTH  FIFO head word; valid whenever `empty`==0
- `shift_out`  out  1  FIFO pop strobe, one cycle per word
- `ser_out`  out  1  serial line; idles high
- `busy`  out  1  high while a frame is in progress (any state except IDLE)
- `frames_sent`  out  CNT_W  count of completed frames; wraps modulo 2^CNT_W

## Operation
- FSM states: IDLE, START, DATA, PAR (only with the macro), STOP.
- **IDLE**
  - `ser_out`=1.
  - `shift_out` = `en` & ~`empty`, combinational, in IDLE only.
  - On the edge where `shift_out`=1, `rdata` is latched into the shift register, the bit-clock counter clears, and the state goes to START.
- **START**: `ser_out`=0 for CLKS_PER_BIT cycles, then DATA.
- **DATA**
  - `ser_out` = shift register bit 0, LSB first.
  - After every CLKS_PER_BIT cycles the register shifts right and the bit index increments.
  - After WIDTH bits, go to PAR if compiled in, else STOP.
- **PAR**: `ser_out` = parity bit for CLKS_PER_BIT cycles, then STOP.
- **STOP**
  - `ser_out`=1 for CLKS_PER_BIT cycles.
  - On the last cycle, `frames_sent` increments and the state goes to IDLE.
- Exactly one `shift_out` pulse per frame. `shift_out` is never asserted while `empty`=1.
- `en` deasserted mid-frame: the current frame completes; no new pop occurs.
- `empty` and `rdata` are ignored outside IDLE. A FIFO refill during a frame has no effect until IDLE.
- Reset mid-frame:
  - All outputs return to reset values immediately (asynchronous).
  - The popped word is discarded; the FIFO is not re-read.
  - The state returns to IDLE.
- Reset values: `shift_out`=0, `ser_out`=1, `busy`=0, `frames_sent`=0, state IDLE, shift register 0, counters 0.

## Timing
- Pop-to-start latency: `ser_out` falls on the rising edge that samples `shift_out`=1. The start bit begins the cycle after the pop cycle.
- Frame length, start of start bit to end of stop bit: (WIDTH+2)·CLKS_PER_BIT cycles, or (WIDTH+3)·CLKS_PER_BIT with parity.
- Back-to-back frames: one IDLE cycle separates frames, during which the next pop occurs. Effective stop is CLKS_PER_BIT+1 high cycles.
- Frame period with a non-empty FIFO and `en`=1: (WIDTH+2)·CLKS_PER_BIT+1 cycles (+CLKS_PER_BIT with parity).
- `busy` rises the cycle after the pop and falls the cycle after the last stop cycle.
- `frames_sent` updates on the edge that leaves STOP, so it is visible while `busy` falls.
- Bit-clock counter width: enough to hold CLKS_PER_BIT-1. Bit index width: enough to hold WIDTH-1.

## Configuration
- `FIFO_SER_TX_PARITY_EN` defined:
  - PAR state is compiled in.
  - Transmits one even-parity bit (XOR of all WIDTH data bits) between the last data bit and stop.
- Not defined: PAR state and parity logic are absent; frame = start + WIDTH data + stop.

## Test plan
- **Reset and idle:** reset with `empty`=1, `en`=1 → `ser_out`=1, `busy`=0, `shift_out`=0, `frames_sent`=0; no pop over 50 cycles.
- **Single word:** WIDTH=16, CLKS_PER_BIT=4, FIFO holds 0xA5C3.
  - One `shift_out` pulse.
  - `ser_out` = 0 (4 cycles), then 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 (4 cycles each), then 1.
  - `frames_sent`=1 after 72 cycles.
  - With the macro: parity 0 precedes stop; frame = 76 cycles.
- **Drain full FIFO:** fill DEPTH=5 random words, `en`=1.
  - Exactly 5 pops; decoded words match write order.
  - Consecutive start bits 73 cycles apart.
  - `frames_sent`=5; `empty`=1 at end.
- **Enable gating:** FIFO holds 2 words; drop `en` during the first frame's DATA state → first frame completes, no second pop. Raise `en` → second frame starts within 1 cycle.
- **Reset mid-frame:** assert `res_n`=0 at data bit 7 of word 0x1234 → `ser_out`=1 and `busy`=0 without waiting for a clock edge. After release, the next FIFO word is transmitted and 0x1234 is not resent.
- **Counter wrap:** CNT_W=2, send 5 frames → `frames_sent` reads 1.
